mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits directly downstream of the icache and dcache controllers and upstream of main memory.
//  Grants a single cache exclusive ownership of the memory port and forwards that cache's mem_req_t.
//  Routes mem_resp_t back to the owner, whose *_grant output qualifies the response.
//  Ownership covers a full miss sequence: optional dirty write-back, then line fill.
//  Ownership is released on fill completion, requester drop, or timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles a granted owner may wait for mem_resp.ready before forced release; min 2
// PORTS
//  clk           in   1             clock; all state on posedge
//  reset         in   1             synchronous, active-high
//  icache_req    in   mem_req_t     icache memory request {valid,rw,addr,data}
//  dcache_req    in   mem_req_t     dcache memory request
//  mem_resp      in   mem_resp_t    memory response {ready,addr,data}; ready = 1-cycle completion pulse
//  icache_grant  out  1             icache owns memory port (registered)
//  dcache_grant  out  1             dcache owns memory port (registered)
//  icache_resp   out  mem_resp_t    mem_resp with ready masked to 0 unless icache_grant
//  dcache_resp   out  mem_resp_t    mem_resp with ready masked to 0 unless dcache_grant
//  mem_req       out  mem_req_t     owner's request; all-zero when no owner
//  timeout_err   out  1             sticky; set on any forced release; cleared only by reset
// BEHAVIOUR
//  Reset (sync, active-high; applies mid-transaction):
//   - state=IDLE; both grants 0; mem_req='0; timeout_err 0; wait counter 0; RR pointer -> icache.
//   - Any in-flight memory op is abandoned; a mem_resp.ready on the reset cycle is ignored.
//  FSM {IDLE, OWN_I, OWN_D}; grants decode from state (OWN_I->icache_grant, OWN_D->dcache_grant).
//  IDLE:
//   - No valid request -> stay in IDLE.
//   - Else pick a winner by the priority rule; go to OWN_I / OWN_D.
//   - Grant rises the cycle after the request is seen (1-cycle arbitration latency).
//  OWN_x:
//   - mem_req = x_req, combinational pass-through, same cycle.
//   - Wait counter increments each cycle and clears on mem_resp.ready.
//   - x_req.valid==0 -> release to IDLE (requester abandoned).
//   - mem_resp.ready && x_req.rw==1 (write-back done) -> stay owned; the read for the fill follows.
//   - mem_resp.ready && x_req.rw==0 (fill done) -> release to IDLE.
//   - Counter reaches TIMEOUT_CYCLES-1 without ready -> release, set timeout_err.
//   - Release cycle: grant still 1, so the response is visible to the owner.
//   - The cycle after a release, grants are 0 (mandatory 1-cycle bubble); a re-grant follows the cycle after that.
//  Simultaneous events:
//   - Ready and valid-drop in the same cycle -> release; the response is still forwarded.
//   - Ready and timeout in the same cycle -> ready wins; timeout_err not set.
//   - Both valid in IDLE -> priority rule decides.
//  Never both grants high; a grant never changes while ready is asserted except at release.
//  Counter width $clog2(TIMEOUT_CYCLES); saturates, never wraps.
// CONFIGURATION
//  MEM_ARB_RR_EN defined:
//   - Round-robin; 1-bit pointer names the last owner.
//   - On a tie the other cache wins; pointer updates at every grant.
//  MEM_ARB_RR_EN undefined:
//   - Fixed priority, dcache > icache; no pointer flop.
// STRUCTURE
//  brisc_pkg holds: mem_req_t, mem_resp_t (existing), new enum arb_state_e {IDLE,OWN_I,OWN_D},
//  and localparam ARB_TIMEOUT_DEFAULT=64.
//  One sub-module: arb_wait_timer (saturating counter, clear, expire output).
//  Priority select stays inline.
// TESTING
//  1 Reset mid-OWN_D with dcache valid -> next cycle both grants 0, mem_req.valid 0, timeout_err 0.
//  2 Icache-only read miss, mem_resp.ready 3 cycles after grant:
//    - icache_grant high cycle+1;
//    - icache_resp.ready pulses once;
//    - dcache_resp.ready stays 0;
//    - grant low the next cycle.
//  3 Dcache dirty miss, write (rw=1) acked, then read acked:
//    - dcache_grant stays high across both responses;
//    - drops only after the read ready;
//    - icache held off the whole time.
//  4 Both valid in IDLE, 3 back-to-back misses each:
//    - RR: grants alternate I,D,I,D,I,D after reset;
//    - fixed priority: D,D,D then I,I,I.
//  5 TIMEOUT_CYCLES=8, memory never responds:
//    - release on the 8th owned cycle;
//    - timeout_err=1 from the next cycle;
//    - the other waiting cache is granted 2 cycles later.
//  6 Owner drops valid in the same cycle as mem_resp.ready:
//    - response is forwarded to the owner;
//    - state goes to IDLE;
//    - no timeout_err.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared memory-interface types for the cache/memory path, plus the
// arbiter state encoding and its default timeout.
package brisc_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Default number of owned cycles without mem_resp.ready before forced release.
  localparam int ARB_TIMEOUT_DEFAULT = 64;

  typedef struct packed {
    logic              valid;
    logic              rw;     // 1 = write (dirty write-back), 0 = read (line fill)
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic              ready;  // one-cycle completion pulse
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_resp_t;

  // One-hot owner encoding so each grant is a single state bit.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating wait counter for the memory arbiter. Counts cycles while
// enabled, clears on request, and flags expiry at LIMIT-1.
module arb_wait_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int              CNT_W   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_r;

  // Count enabled cycles; clear has priority; hold at the terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en && (count_r == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter between icache and dcache. One cache owns the port for
// a whole miss sequence (optional write-back, then fill). Ownership ends on
// fill completion, requester drop, or timeout (which sets sticky timeout_err).
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise
// fixed priority with dcache ahead of icache.
import brisc_pkg::*;

module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  mem_req_t  icache_req,
  input  mem_req_t  dcache_req,
  input  mem_resp_t mem_resp,
  output logic      icache_grant,
  output logic      dcache_grant,
  output mem_resp_t icache_resp,
  output mem_resp_t dcache_resp,
  output mem_req_t  mem_req,
  output logic      timeout_err
);

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  mem_req_t   owner_req_s;
  logic       own_s;
  logic       pick_d_s;
  logic       expire_s;
  logic       timer_clr_s;
  logic       timeout_set_s;
  logic       timeout_err_r;

`ifdef MEM_ARB_RR_EN
  logic       last_d_r;   // 1 = dcache was the last cache granted
`endif

  assign own_s = (state_r == OWN_I) || (state_r == OWN_D);

  // Pick the winner among valid requesters; only used from IDLE.
  always_comb begin
    pick_d_s = 1'b0;
    if (icache_req.valid && dcache_req.valid) begin
`ifdef MEM_ARB_RR_EN
      pick_d_s = ~last_d_r;
`else
      pick_d_s = 1'b1;
`endif
    end else if (dcache_req.valid) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
  end

  // Select the owner's request; nothing is forwarded without an owner.
  always_comb begin
    owner_req_s = '0;
    case (state_r)
      OWN_I:   owner_req_s = icache_req;
      OWN_D:   owner_req_s = dcache_req;
      default: owner_req_s = '0;
    endcase
  end

  // Next-state: grant from IDLE, release on drop / fill done / timeout.
  always_comb begin
    state_nxt_s   = state_r;
    timeout_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (icache_req.valid || dcache_req.valid) begin
          state_nxt_s = pick_d_s ? OWN_D : OWN_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN_I, OWN_D: begin
        if (!owner_req_s.valid) begin
          state_nxt_s = IDLE;
        end else if (mem_resp.ready) begin
          // A completed write-back keeps ownership for the fill read.
          state_nxt_s = owner_req_s.rw ? state_r : IDLE;
        end else if (expire_s) begin
          state_nxt_s   = IDLE;
          timeout_set_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Restart the wait count whenever not owned, on a response, or on release.
  always_comb begin
    timer_clr_s = 1'b0;
    if (!own_s || mem_resp.ready || (state_nxt_s == IDLE)) begin
      timer_clr_s = 1'b1;
    end else begin
      timer_clr_s = 1'b0;
    end
  end

  arb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr_s),
    .en     (own_s),
    .expire (expire_s)
  );

  // Ownership state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_set_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember the last owner so the other cache wins the next tie; after
  // reset icache is favoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_r <= 1'b1;
    end else if ((state_r == IDLE) && (state_nxt_s != IDLE)) begin
      last_d_r <= pick_d_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end
`endif

  assign icache_grant = (state_r == OWN_I);
  assign dcache_grant = (state_r == OWN_D);
  assign mem_req      = owner_req_s;
  assign timeout_err  = timeout_err_r;

  // Route the response; ready reaches only the owner and never during reset.
  always_comb begin
    icache_resp       = mem_resp;
    dcache_resp       = mem_resp;
    icache_resp.ready = mem_resp.ready & icache_grant & ~reset;
    dcache_resp.ready = mem_resp.ready & dcache_grant & ~reset;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grant order and routed
// responses are queued as stimulus is driven and checked on the falling edge.
module tb_mem_arbiter;
  import brisc_pkg::*;

  localparam int TO = 8;

  logic      clk = 1'b0;
  logic      reset;
  mem_req_t  icache_req;
  mem_req_t  dcache_req;
  mem_resp_t mem_resp;
  logic      icache_grant;
  logic      dcache_grant;
  mem_resp_t icache_resp;
  mem_resp_t dcache_resp;
  mem_req_t  mem_req;
  logic      timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  logic              exp_grant_q[$];  // 0 = icache, 1 = dcache
  logic [DATA_W:0]   exp_resp_q[$];   // {owner, data}
  logic              prev_i = 1'b0;
  logic              prev_d = 1'b0;

`ifdef MEM_ARB_RR_EN
  localparam logic RR_BUILD = 1'b1;
`else
  localparam logic RR_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .icache_req   (icache_req),
    .dcache_req   (dcache_req),
    .mem_resp     (mem_resp),
    .icache_grant (icache_grant),
    .dcache_grant (dcache_grant),
    .icache_resp  (icache_resp),
    .dcache_resp  (dcache_resp),
    .mem_req      (mem_req),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mem_req_t rq(input logic v, input logic rw, input logic [31:0] a,
                                  input logic [31:0] d);
    mem_req_t r;
    r.valid = v;
    r.rw    = rw;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_resp(input logic [31:0] d, input logic owner);
    mem_resp.ready = 1'b1;
    mem_resp.addr  = 32'h0000_0ABC;
    mem_resp.data  = d;
    exp_resp_q.push_back({owner, d});
  endtask

  task automatic reset_pulse();
    next_cycle();
    reset      = 1'b1;
    icache_req = '0;
    dcache_req = '0;
    mem_resp   = '0;
    sample();
    next_cycle();
    reset = 1'b0;
    sample();
  endtask

  // Grant-order scoreboard, response routing scoreboard, mutual exclusion.
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    logic            g;
    check("one_grant", 128'(icache_grant & dcache_grant), 128'd0);
    if (icache_grant && !prev_i) begin
      if (exp_grant_q.size() == 0) check("grant_unexpected_i", 128'd1, 128'd0);
      else begin g = exp_grant_q.pop_front(); check("grant_owner", 128'd0, 128'(g)); end
    end
    if (dcache_grant && !prev_d) begin
      if (exp_grant_q.size() == 0) check("grant_unexpected_d", 128'd1, 128'd0);
      else begin g = exp_grant_q.pop_front(); check("grant_owner", 128'd1, 128'(g)); end
    end
    prev_i = icache_grant;
    prev_d = dcache_grant;
    if (icache_resp.ready || dcache_resp.ready) begin
      if (exp_resp_q.size() == 0) begin
        check("resp_unexpected", 128'd1, 128'd0);
      end else begin
        e = exp_resp_q.pop_front();
        check("resp_owner", 128'({dcache_resp.ready, icache_resp.ready}),
              128'(e[DATA_W] ? 2'b10 : 2'b01));
        check("resp_data", 128'(e[DATA_W] ? dcache_resp.data : icache_resp.data),
              128'(e[DATA_W-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       order [6];
    int         rem_i;
    int         rem_d;
    int         k;
    logic       held;
    logic       first;
    logic       other;

    reset      = 1'b1;
    icache_req = '0;
    dcache_req = '0;
    mem_resp   = '0;
    next_cycle();
    next_cycle();
    sample();
    check("rst_igrant", 128'(icache_grant), 128'd0);
    check("rst_dgrant", 128'(dcache_grant), 128'd0);
    check("rst_mem_req", 128'(mem_req), 128'd0);
    check("rst_timeout_err", 128'(timeout_err), 128'd0);

    // 1: reset while dcache owns the port, with a ready on the reset cycle
    next_cycle();
    reset      = 1'b0;
    dcache_req = rq(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    exp_grant_q.push_back(1'b1);
    sample();
    check("t1_pre_grant", 128'(dcache_grant), 128'd0);
    next_cycle();
    reset         = 1'b1;
    mem_resp.ready = 1'b1;
    mem_resp.data  = 32'h5A5A_0000;
    sample();
    check("t1_owned", 128'(dcache_grant), 128'd1);
    check("t1_reset_resp_masked", 128'(dcache_resp.ready), 128'd0);
    next_cycle();
    mem_resp = '0;
    sample();
    check("t1_igrant", 128'(icache_grant), 128'd0);
    check("t1_dgrant", 128'(dcache_grant), 128'd0);
    check("t1_req_valid", 128'(mem_req.valid), 128'd0);
    check("t1_timeout_err", 128'(timeout_err), 128'd0);
    next_cycle();
    reset      = 1'b0;
    dcache_req = '0;
    sample();

    // 2: icache read miss, response three cycles after grant
    next_cycle();
    icache_req = rq(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    exp_grant_q.push_back(1'b0);
    sample();
    check("t2_no_grant_yet", 128'(icache_grant), 128'd0);
    next_cycle();
    sample();
    check("t2_grant", 128'(icache_grant), 128'd1);
    check("t2_mem_req", 128'(mem_req), 128'(icache_req));
    next_cycle();
    sample();
    next_cycle();
    sample();
    next_cycle();
    drive_resp(32'h1111_0001, 1'b0);
    sample();
    check("t2_dresp_zero", 128'(dcache_resp.ready), 128'd0);
    check("t2_grant_at_release", 128'(icache_grant), 128'd1);
    next_cycle();
    mem_resp   = '0;
    icache_req = '0;
    sample();
    check("t2_released", 128'(icache_grant), 128'd0);

    // 3: dcache dirty miss (write-back then fill) while icache waits
    next_cycle();
    dcache_req = rq(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_0001);
    icache_req = rq(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    exp_grant_q.push_back(1'b1);
    sample();
    next_cycle();
    sample();
    check("t3_dgrant", 128'(dcache_grant), 128'd1);
    check("t3_mem_req_wb", 128'(mem_req), 128'(dcache_req));
    next_cycle();
    drive_resp(32'h0000_0000, 1'b1);
    sample();
    check("t3_dgrant_wb_ack", 128'(dcache_grant), 128'd1);
    next_cycle();
    mem_resp   = '0;
    dcache_req = rq(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    sample();
    check("t3_dgrant_held", 128'(dcache_grant), 128'd1);
    check("t3_igrant_off", 128'(icache_grant), 128'd0);
    check("t3_mem_req_fill", 128'(mem_req), 128'(dcache_req));
    next_cycle();
    sample();
    next_cycle();
    drive_resp(32'hCAFE_0002, 1'b1);
    sample();
    check("t3_dgrant_fill_ack", 128'(dcache_grant), 128'd1);
    next_cycle();
    mem_resp   = '0;
    dcache_req = '0;
    exp_grant_q.push_back(1'b0);
    sample();
    check("t3_bubble_d", 128'(dcache_grant), 128'd0);
    check("t3_bubble_i", 128'(icache_grant), 128'd0);
    next_cycle();
    sample();
    check("t3_igrant_after", 128'(icache_grant), 128'd1);
    next_cycle();
    drive_resp(32'h3333_0003, 1'b0);
    sample();
    next_cycle();
    mem_resp   = '0;
    icache_req = '0;
    sample();

    // 4: both caches with three back-to-back misses each
    reset_pulse();
    if (RR_BUILD) order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    else          order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) exp_grant_q.push_back(order[i]);
    rem_i = 3;
    rem_d = 3;
    k     = 0;
    held  = 1'b0;
    icache_req = rq(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    dcache_req = rq(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    for (int c = 0; c < 60 && k < 6; c++) begin
      next_cycle();
      mem_resp         = '0;
      icache_req.valid = (rem_i != 0);
      dcache_req.valid = (rem_d != 0);
      if ((icache_grant || dcache_grant) && held) begin
        drive_resp(32'h4000_0000 + 32'(k), order[k]);
        if (order[k]) rem_d--;
        else          rem_i--;
        k++;
        held = 1'b0;
      end else begin
        held = icache_grant || dcache_grant;
      end
      sample();
    end
    check("t4_all_served", 128'(k), 128'd6);
    next_cycle();
    mem_resp   = '0;
    icache_req = '0;
    dcache_req = '0;
    sample();
    check("t4_grant_q_empty", 128'(exp_grant_q.size()), 128'd0);

    // 5: memory never answers; forced release on the 8th owned cycle
    reset_pulse();
    first = RR_BUILD ? 1'b0 : 1'b1;
    other = ~first;
    next_cycle();
    icache_req = rq(1'b1, 1'b0, 32'h0000_0600, 32'h0);
    dcache_req = rq(1'b1, 1'b0, 32'h0000_0700, 32'h0);
    exp_grant_q.push_back(first);
    sample();
    for (int n = 1; n <= TO; n++) begin
      next_cycle();
      sample();
      check("t5_owned", 128'(first ? dcache_grant : icache_grant), 128'd1);
      check("t5_no_err_yet", 128'(timeout_err), 128'd0);
    end
    next_cycle();
    if (first) dcache_req = '0;
    else       icache_req = '0;
    exp_grant_q.push_back(other);
    sample();
    check("t5_bubble", 128'({icache_grant, dcache_grant}), 128'd0);
    check("t5_err_set", 128'(timeout_err), 128'd1);
    next_cycle();
    sample();
    check("t5_other_granted", 128'(other ? dcache_grant : icache_grant), 128'd1);
    check("t5_err_sticky", 128'(timeout_err), 128'd1);
    next_cycle();
    drive_resp(32'h5555_0005, other);
    sample();
    next_cycle();
    mem_resp   = '0;
    icache_req = '0;
    dcache_req = '0;
    sample();
    check("t5_err_still_set", 128'(timeout_err), 128'd1);

    // 6: owner drops valid on the same cycle memory answers
    reset_pulse();
    check("t6_err_cleared", 128'(timeout_err), 128'd0);
    next_cycle();
    icache_req = rq(1'b1, 1'b0, 32'h0000_0800, 32'h0);
    exp_grant_q.push_back(1'b0);
    sample();
    next_cycle();
    sample();
    check("t6_grant", 128'(icache_grant), 128'd1);
    next_cycle();
    icache_req = '0;
    drive_resp(32'h6666_0006, 1'b0);
    sample();
    check("t6_grant_at_release", 128'(icache_grant), 128'd1);
    next_cycle();
    mem_resp = '0;
    sample();
    check("t6_idle_i", 128'(icache_grant), 128'd0);
    check("t6_idle_d", 128'(dcache_grant), 128'd0);
    check("t6_mem_req_zero", 128'(mem_req), 128'd0);
    check("t6_no_timeout", 128'(timeout_err), 128'd0);

    check("end_grant_q_empty", 128'(exp_grant_q.size()), 128'd0);
    check("end_resp_q_empty", 128'(exp_resp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
